// File: rtl/rk_pkg.sv
// Shared types and FP64 helpers for the RK step sequencer.
package rk_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StCapture,
    StStall,
    StDone
  } rk_state_t;

  localparam int unsigned FP64_EXP_MSB = 62;
  localparam int unsigned FP64_EXP_LSB = 52;
  localparam int unsigned FP64_MANT_W  = 52;

  // Quiet or signalling NaN: exponent all ones, mantissa non-zero (infinity excluded).
  function automatic logic fp64_is_nan(input logic [63:0] v);
    return (&v[FP64_EXP_MSB:FP64_EXP_LSB]) && (|v[FP64_MANT_W-1:0]);
  endfunction

endpackage

// File: rtl/rk_step_sequencer_if.sv
// Integrator launch/result pair plus the valid/ready result stream.
interface rk_step_sequencer_if;
  logic        rk_start;
  logic [63:0] rk_result;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output rk_start,
    output out_data,
    output out_valid,
    input  rk_result,
    input  out_ready
  );

  modport slave (
    input  rk_start,
    input  out_data,
    input  out_valid,
    output rk_result,
    output out_ready
  );
endinterface

// File: rtl/rk_result_fifo.sv
// Result FIFO; head is read straight from storage flops, so a push shows up one cycle later.
module rk_result_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLvl  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AfullLvl = (AW+1)'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level;
  logic             push_ok, pop_ok;

  // Extra pointer MSB separates full from empty.
  always_comb begin
    level         = wr_ptr_q - rd_ptr_q;
    full_o        = (level == FullLvl);
    empty_o       = (level == '0);
    almost_full_o = (level == AfullLvl);
    pop_ok        = pop_i && !empty_o;
    push_ok       = push_i && (!full_o || pop_i);
    wr_ptr_d      = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    data_o        = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer and storage update; reset flushes contents so the head reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end
endmodule

// File: rtl/rk_step_sequencer.sv
// Launches n_steps integrator runs, captures each result after a fixed latency and queues it.
module rk_step_sequencer
  import rk_pkg::*;
#(
  parameter int unsigned RK_LATENCY = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned STEP_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go_i,
  input  logic [STEP_W-1:0]        n_steps_i,
  rk_step_sequencer_if.master      bus,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     nan_seen_o
);
  localparam logic [7:0] WaitInit = 8'(RK_LATENCY - 1);

  rk_state_t         state_q, state_d;
  logic [STEP_W-1:0] steps_left_q, steps_left_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              nan_q, nan_d;
  logic              push, pop, rk_start;
  logic              fifo_full, fifo_empty, fifo_afull;
  logic [63:0]       fifo_head;

  assign pop           = !fifo_empty && bus.out_ready;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head;
  assign bus.rk_start  = rk_start;
  assign busy_o        = (state_q != StIdle);
  assign nan_seen_o    = nan_q;

  // Next-state, counters and per-state strobes.
  always_comb begin
    state_d      = state_q;
    steps_left_d = steps_left_q;
    wait_cnt_d   = wait_cnt_q;
    nan_d        = nan_q;
    push         = 1'b0;
    rk_start     = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go_i) begin
          steps_left_d = n_steps_i;
          nan_d        = 1'b0;
          state_d      = (n_steps_i == '0) ? StDone : StLaunch;
        end
      end
      StLaunch: begin
        rk_start   = 1'b1;
        wait_cnt_d = WaitInit;
        state_d    = (RK_LATENCY == 1) ? StCapture : StWait;
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q - 8'd1;
        if (wait_cnt_q <= 8'd1) state_d = StCapture;
      end
      StCapture: begin
        push         = 1'b1;
        steps_left_d = steps_left_q - STEP_W'(1);
        if (fp64_is_nan(bus.rk_result)) nan_d = 1'b1;
        if (steps_left_q == STEP_W'(1)) state_d = StDone;
        // Only relaunch when the next capture is sure to find a free slot.
        else if (fifo_afull && !pop)    state_d = StStall;
        else                            state_d = StLaunch;
      end
      StStall: begin
        if (!fifo_full || pop) state_d = StLaunch;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      steps_left_q <= '0;
      wait_cnt_q   <= '0;
      nan_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      steps_left_q <= steps_left_d;
      wait_cnt_q   <= wait_cnt_d;
      nan_q        <= nan_d;
    end
  end

  rk_result_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push_i        (push),
    .data_i        (bus.rk_result),
    .pop_i         (pop),
    .data_o        (fifo_head),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .almost_full_o (fifo_afull)
  );
endmodule

// File: tb/tb_rk_step_sequencer.sv
// Directed bench: latency-4 instance for the main scenarios, latency-1 instance for step spacing.
module tb_rk_step_sequencer;
  localparam logic [63:0] OneP5   = 64'h3FF8000000000000;
  localparam logic [63:0] One     = 64'h3FF0000000000000;
  localparam logic [63:0] QNan    = 64'h7FF8000000000001;
  localparam logic [63:0] PInf    = 64'h7FF0000000000000;
  localparam logic [63:0] SeqBase = 64'h4000000000000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0, go1 = 1'b0;
  logic [15:0] n_steps = '0, n_steps1 = '0;
  logic        busy, done, nan_seen, busy1, done1, nan_seen1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  int          rk_mode = 0;
  logic [63:0] const_val = OneP5;
  int          launches[$], done_cyc[$], nan_rise[$], launches1[$], done_cyc1[$];
  logic [63:0] samples[$], samples1[$];
  logic        done_busy = 1'b0;
  logic        nan_prev = 1'b0;

  rk_step_sequencer_if bus ();
  rk_step_sequencer_if bus1 ();

  rk_step_sequencer #(.RK_LATENCY(4), .FIFO_DEPTH(8), .STEP_W(16)) dut (
    .clk(clk), .rst(rst), .go_i(go), .n_steps_i(n_steps), .bus(bus),
    .busy_o(busy), .done_o(done), .nan_seen_o(nan_seen)
  );

  rk_step_sequencer #(.RK_LATENCY(1), .FIFO_DEPTH(8), .STEP_W(16)) dut1 (
    .clk(clk), .rst(rst), .go_i(go1), .n_steps_i(n_steps1), .bus(bus1),
    .busy_o(busy1), .done_o(done1), .nan_seen_o(nan_seen1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input bit which, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((which ? done_cyc1.size() : done_cyc.size()) != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_logs();
    launches.delete(); done_cyc.delete(); nan_rise.delete(); samples.delete();
    launches1.delete(); done_cyc1.delete(); samples1.delete();
  endtask

  // Negedge monitor: logs launches, pops, done pulses; drives the integrator result.
  initial begin
    bus1.rk_result = OneP5;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.rk_start) launches.push_back(cyc);
        if (bus.out_valid && bus.out_ready) samples.push_back(bus.out_data);
        if (done) begin
          done_cyc.push_back(cyc);
          done_busy = busy;
        end
        if (nan_seen && !nan_prev) nan_rise.push_back(cyc);
        if (bus1.rk_start) launches1.push_back(cyc);
        if (bus1.out_valid && bus1.out_ready) samples1.push_back(bus1.out_data);
        if (done1) done_cyc1.push_back(cyc);
      end
      nan_prev = nan_seen;
      case (rk_mode)
        1:       bus.rk_result = SeqBase + 64'(launches.size());
        2:       bus.rk_result = (launches.size() == 2) ? QNan :
                                 (launches.size() == 3) ? PInf : One;
        default: bus.rk_result = const_val;
      endcase
    end
  end

  initial begin
    int n0;
    int s_cyc;
    bit ok;
    bus.out_ready  = 1'b1;
    bus1.out_ready = 1'b1;

    // Reset state
    tick(3);
    check_eq("rst_rk_start", 64'(bus.rk_start), 64'd0);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_out_data", bus.out_data, 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_nan", 64'(nan_seen), 64'd0);
    rst = 1'b0;
    tick(2);

    // Basic run: 3 steps of 1.5, latency 4
    clear_logs();
    rk_mode = 0; const_val = OneP5;
    n0 = cyc; go = 1'b1; n_steps = 16'd3;
    tick(); go = 1'b0;
    check_eq("basic_rk_start_now", 64'(bus.rk_start), 64'd1);
    wait_done(1'b0, 100, ok);
    check_eq("basic_done_timeout", 64'(ok), 64'd1);
    check_eq("basic_busy_after_done", 64'(busy), 64'd0);
    check_eq("basic_busy_at_done", 64'(done_busy), 64'd1);
    tick(2);
    check_eq("basic_n_launch", 64'(launches.size()), 64'd3);
    if (launches.size() == 3) begin
      check_eq("basic_first_launch", 64'(launches[0]), 64'(n0 + 1));
      check_eq("basic_gap01", 64'(launches[1] - launches[0]), 64'd5);
      check_eq("basic_gap12", 64'(launches[2] - launches[1]), 64'd5);
      if (done_cyc.size() != 0)
        check_eq("basic_done_cycle", 64'(done_cyc[0]), 64'(launches[2] + 5));
    end
    check_eq("basic_n_samples", 64'(samples.size()), 64'd3);
    foreach (samples[i]) check_eq("basic_sample", samples[i], OneP5);

    // Zero steps: immediate done, no launch
    clear_logs();
    go = 1'b1; n_steps = 16'd0;
    tick(); go = 1'b0;
    check_eq("zero_done", 64'(done), 64'd1);
    check_eq("zero_rk_start", 64'(bus.rk_start), 64'd0);
    tick();
    check_eq("zero_busy_after", 64'(busy), 64'd0);
    tick(5);
    check_eq("zero_n_launch", 64'(launches.size()), 64'd0);

    // Backpressure: 12 steps into an 8-deep FIFO with ready low
    clear_logs();
    rk_mode = 1; bus.out_ready = 1'b0;
    go = 1'b1; n_steps = 16'd12;
    tick(); go = 1'b0;
    tick(60);
    check_eq("bp_n_launch_stalled", 64'(launches.size()), 64'd8);
    check_eq("bp_no_samples", 64'(samples.size()), 64'd0);
    check_eq("bp_busy", 64'(busy), 64'd1);
    check_eq("bp_out_valid", 64'(bus.out_valid), 64'd1);
    s_cyc = cyc; bus.out_ready = 1'b1;
    tick(); bus.out_ready = 1'b0;
    tick(8);
    check_eq("bp_one_more_launch", 64'(launches.size()), 64'd9);
    if (launches.size() >= 9)
      check_eq("bp_release_cycle", 64'(launches[8]), 64'(s_cyc + 1));
    check_eq("bp_one_pop", 64'(samples.size()), 64'd1);
    bus.out_ready = 1'b1;
    wait_done(1'b0, 300, ok);
    check_eq("bp_done_timeout", 64'(ok), 64'd1);
    tick(12);
    check_eq("bp_n_samples", 64'(samples.size()), 64'd12);
    foreach (samples[i]) check_eq("bp_sample_order", samples[i], SeqBase + 64'(i + 1));

    // NaN on step 2 of 4 sets sticky flag; +Inf alone does not
    clear_logs();
    rk_mode = 2;
    go = 1'b1; n_steps = 16'd4;
    tick(); go = 1'b0;
    wait_done(1'b0, 100, ok);
    check_eq("nan_done_timeout", 64'(ok), 64'd1);
    check_eq("nan_sticky", 64'(nan_seen), 64'd1);
    check_eq("nan_n_rise", 64'(nan_rise.size()), 64'd1);
    if (nan_rise.size() != 0 && launches.size() >= 2)
      check_eq("nan_rise_cycle", 64'(nan_rise[0]), 64'(launches[1] + 5));
    tick(2);
    clear_logs();
    rk_mode = 0; const_val = PInf;
    go = 1'b1; n_steps = 16'd1;
    tick(); go = 1'b0;
    check_eq("inf_nan_cleared_by_go", 64'(nan_seen), 64'd0);
    wait_done(1'b0, 50, ok);
    tick(2);
    check_eq("inf_nan_stays_low", 64'(nan_seen), 64'd0);
    check_eq("inf_n_samples", 64'(samples.size()), 64'd1);
    if (samples.size() != 0) check_eq("inf_sample", samples[0], PInf);

    // Reset during WAIT of step 2 with one sample queued
    clear_logs();
    const_val = OneP5; bus.out_ready = 1'b0;
    go = 1'b1; n_steps = 16'd3;
    tick(); go = 1'b0;
    tick(7);
    check_eq("mid_queued", 64'(bus.out_valid), 64'd1);
    check_eq("mid_two_launches", 64'(launches.size()), 64'd2);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("mid_rst_out_data", bus.out_data, 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_rk_start", 64'(bus.rk_start), 64'd0);
    tick(2);
    rst = 1'b0;
    clear_logs();
    tick(3);
    check_eq("mid_valid_stays_low", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    go = 1'b1; n_steps = 16'd1;
    tick(); go = 1'b0;
    wait_done(1'b0, 50, ok);
    check_eq("mid_done_timeout", 64'(ok), 64'd1);
    tick(3);
    check_eq("mid_one_launch", 64'(launches.size()), 64'd1);
    check_eq("mid_one_sample", 64'(samples.size()), 64'd1);

    // go while busy is ignored
    clear_logs();
    go = 1'b1; n_steps = 16'd3;
    tick(); go = 1'b0;
    tick(2);
    go = 1'b1; n_steps = 16'd7;
    tick(); go = 1'b0;
    wait_done(1'b0, 100, ok);
    tick(3);
    check_eq("ign_n_launch", 64'(launches.size()), 64'd3);
    check_eq("ign_n_samples", 64'(samples.size()), 64'd3);

    // Latency 1: steps two cycles apart
    clear_logs();
    go1 = 1'b1; n_steps1 = 16'd3;
    tick(); go1 = 1'b0;
    wait_done(1'b1, 50, ok);
    check_eq("l1_done_timeout", 64'(ok), 64'd1);
    check_eq("l1_busy_after", 64'(busy1), 64'd0);
    tick(2);
    check_eq("l1_n_launch", 64'(launches1.size()), 64'd3);
    if (launches1.size() == 3) begin
      check_eq("l1_gap01", 64'(launches1[1] - launches1[0]), 64'd2);
      check_eq("l1_gap12", 64'(launches1[2] - launches1[1]), 64'd2);
      if (done_cyc1.size() != 0)
        check_eq("l1_done_cycle", 64'(done_cyc1[0]), 64'(launches1[2] + 2));
    end
    check_eq("l1_n_samples", 64'(samples1.size()), 64'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rk_step_sequencer.md
# rk_step_sequencer

Controller and result buffer directly downstream of `runge_kutta`.
- On `go`, issues `n_steps` one-cycle `start` pulses to the integrator and samples its 64-bit IEEE-754 double output (`GERVACIO`) a fixed `RK_LATENCY` cycles after each pulse.
- Queues the samples in a small FIFO and streams them out on a valid/ready port to the logging/host side.
- Flags NaN results and lost-data conditions.

## Interface
Parameters:
- `RK_LATENCY`, 4, cycles from `rk_start` cycle to result-valid cycle; legal range 1..255.
- `FIFO_DEPTH`, 8, result FIFO entries; power of two, ≥2.
- `STEP_W`, 16, width of the step count.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `go`  in  1  start a run; sampled only in IDLE.
- `n_steps`  in  STEP_W  steps for the run; sampled with `go`.
- `rk_start`  out  1  to `runge_kutta.start`.
- `rk_result`  in  64  from `runge_kutta.GERVACIO` (FP64 bits).
- `out_data`  out  64  FIFO head.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse at end of run.
- `nan_seen`  out  1  sticky; a captured sample was NaN.

## Operation
- The FSM has states IDLE, LAUNCH, WAIT, CAPTURE, STALL and DONE.
- **IDLE:** on `go`, load `steps_left ← n_steps` and clear `nan_seen`.
  - If `n_steps == 0`, go to DONE.
  - Otherwise go to LAUNCH.
- **LAUNCH:** `rk_start = 1` for exactly this cycle. Load `wait_cnt ← RK_LATENCY-1`.
  - Go to WAIT, or to CAPTURE if `RK_LATENCY == 1`.
- **WAIT:** decrement `wait_cnt`; at 1, go to CAPTURE.
- **CAPTURE:** push `rk_result` into the FIFO and decrement `steps_left`.
  - Set `nan_seen` if exponent bits [62:52] are all ones and mantissa [51:0] ≠ 0.
  - If `steps_left` becomes 0, go to DONE.
  - Else if the FIFO is full after the push, go to STALL.
  - Else go to LAUNCH.
- **STALL:** hold with no launch until the FIFO is not full, then go to LAUNCH.
  - The integrator is never launched unless a free FIFO slot is guaranteed, so no sample is ever dropped.
- **DONE:** `done = 1` for one cycle, then go to IDLE. Remaining FIFO contents keep draining.
- `go` outside IDLE is ignored.
- **FIFO:**
  - Pop occurs when `out_valid && out_ready`.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo `FIFO_DEPTH`. Full and empty are distinguished with an extra pointer bit.
- All values pass through bit-exact; no FP arithmetic is performed.

## Timing
- **Reset values:** state IDLE; `rk_start`, `out_valid`, `busy`, `done` and `nan_seen` are 0; `out_data` is 0. FIFO pointers, `steps_left` and `wait_cnt` are 0.
- **Reset mid-run:** abort immediately and flush the FIFO. The first `go` after `rst` deasserts starts a clean run.
- **Launch latency:** with `go` high at edge e, LAUNCH is the cycle after e and `rk_start` is high during it.
  - If LAUNCH is cycle t, CAPTURE is cycle t+RK_LATENCY.
  - The next LAUNCH is cycle t+RK_LATENCY+1 when not stalled, so each step costs RK_LATENCY+1 cycles.
- **Output latency:** a sample pushed in cycle c appears on `out_data` with `out_valid = 1` in cycle c+1. There is no bypass.
- **Output handshake:**
  - `out_data` and `out_valid` are registered.
  - `out_data` is stable while `out_valid && !out_ready`.
- **Stall release:** when a pop frees a slot in STALL cycle s, LAUNCH is cycle s+1.
- **`done`:** occurs in the cycle after the last CAPTURE. `busy` falls in the following cycle.

## Structure
- **Package `rk_pkg`:**
  - `rk_state_t` enum.
  - FP64 field constants: `FP64_EXP_MSB = 62`, `FP64_EXP_LSB = 52`, `FP64_MANT_W = 52`.
  - Function `fp64_is_nan`.
- **Sub-module `rk_result_fifo`:** parameterised by width (64) and `FIFO_DEPTH`.
  - Outputs `full`, `empty`, and the registered head.
- **Top `rk_step_sequencer`:** FSM and counters only.

## Test plan
- **Basic run:** `RK_LATENCY = 4`, `n_steps = 3`, `rk_result` driven to `64'h3FF8000000000000` (1.5), `out_ready = 1`.
  - Expect `rk_start` pulses 5 cycles apart and three outputs of 1.5.
  - `done` fires 1 cycle after the third capture; `busy` falls the cycle after.
- **Zero steps:** `n_steps = 0` → no `rk_start`; `done` is high the cycle after `go`.
- **Backpressure:** `FIFO_DEPTH = 8`, `n_steps = 12`, `out_ready = 0`.
  - After 8 captures, the block holds in STALL with no further `rk_start`.
  - Raising `out_ready` for one cycle produces exactly one new LAUNCH the next cycle.
  - All 12 values are eventually received in order with no loss.
- **NaN flag:** `rk_result = 64'h7FF8000000000001` on step 2 of 4 → `nan_seen` rises after that capture and stays 1 until the next `go`. `64'h7FF0000000000000` (+Inf) does not set it.
- **Reset mid-run:** assert `rst` during WAIT of step 2 with 1 sample queued.
  - All outputs are 0 immediately and `out_valid` stays 0.
  - A new `go` with `n_steps = 1` yields exactly one sample.
- **Ignored go / edge latency:** pulse `go` while busy → the step count is unchanged. With `RK_LATENCY = 1`, steps run 2 cycles apart.
